bram2_stall_port_arbiter: RTL
=============================

Name: bram2_stall_port_arbiter

Overview:
- Shares one port of the stall-capable dual-port BRAM (the read-output register holds unless that port is enabled or dequeued) between two requesters.
- Round-robin arbitration over valid/ready request channels.
- Tracks in-flight reads in a shadow valid/tag pipeline that mirrors the BRAM read pipeline, and routes each read response to its owner.
- Drives the port's DEQ pulse so a stalled consumer never loses data; the other BRAM port is owned elsewhere.

Parameters:
- ADDR_WIDTH, 10, BRAM address width.
- DATA_WIDTH, 32, BRAM data width.
- PIPELINED, 0, must match the BRAM instance. Read latency L = 1 when 0, L = 2 when 1.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- REQ0_VALID  in  1  client 0 request valid.
- REQ0_READY  out  1  client 0 request accepted this cycle.
- REQ0_WRITE  in  1  1 = write, 0 = read.
- REQ0_ADDR  in  ADDR_WIDTH  client 0 address.
- REQ0_DATA  in  DATA_WIDTH  client 0 write data.
- RSP0_VALID  out  1  client 0 read data valid.
- RSP0_READY  in  1  client 0 consumes the response.
- RSP0_DATA  out  DATA_WIDTH  client 0 read data.
- REQ1_* / RSP1_*  as for client 0, same widths.
- BRAM_EN  out  1  to BRAM EN.
- BRAM_WE  out  1  to BRAM WE.
- BRAM_ADDR  out  ADDR_WIDTH  to BRAM ADDR.
- BRAM_DI  out  DATA_WIDTH  to BRAM DI.
- BRAM_DEQ  out  1  to BRAM DEQ.
- BRAM_DO  in  DATA_WIDTH  from BRAM DO.

Behaviour:
- Shadow pipeline: L stages, each {valid, tag}.
  - Shifts exactly when CE = BRAM_EN | BRAM_DEQ.
  - Stage 0 loads {issue_is_read, grant}.
  - Head = stage L-1.
- Response channel:
  - RSPt_VALID = head.valid && head.tag == t.
  - RSPt_DATA = BRAM_DO, routed combinationally to both clients; it is qualified only by RSPt_VALID.
  - head_accept = head.valid && RSP[head.tag]_READY.
- Issue:
  - can_issue = !head.valid || head_accept.
  - A read or write may issue only when can_issue is true; a shift must never overwrite an unconsumed head.
- Arbitration:
  - Round-robin with a 1-bit priority pointer; reset value 0 (client 0 preferred).
  - If only one client is valid, it wins.
  - If both are valid, the pointer-preferred client wins; after any grant the pointer points to the non-granted client.
  - REQt_READY = can_issue && grant == t && REQt_VALID.
- BRAM drive on issue:
  - BRAM_EN = 1, BRAM_WE = REQ_WRITE, ADDR/DI muxed from the granted client.
  - When idle: EN = 0 and ADDR/DI = 0.
- Writes: insert a bubble (valid = 0) into stage 0 and produce no response. Write-then-read to the same address in consecutive cycles returns the new data.
- Bubble drain: BRAM_DEQ = !BRAM_EN && (head_accept || (!head.valid && any stage valid)). Bubbles ahead of a valid read therefore collapse without a client request.
- Simultaneous events: a head accept and a new issue in the same cycle give one shift with EN = 1 and DEQ = 0. This sustains full throughput of 1 op/cycle with continuous ready.
- Stall: with the head valid and RSP_READY low, EN = DEQ = 0. RSP_VALID and RSP_DATA hold stable indefinitely.
- Reset values, with RST high in any cycle including mid-operation:
  - All shadow valids cleared, pointer = 0.
  - All outputs 0 in the cycle after RST is sampled high; BRAM_EN and BRAM_DEQ are gated low while RST is high.
  - Reads in flight are discarded silently; writes already issued remain in memory.
- Latency: a read issued in cycle n has RSP_VALID in cycle n+L at the earliest.

Decomposition:
- Shared package holds:
  - a client-tag typedef (1 bit);
  - a localparam function computing L from PIPELINED;
  - a request struct {write, addr, data}.
- One natural sub-module: bram2_rr_arb2, a 2-way round-robin arbiter containing the pointer register, req → grant logic and an advance input.
- Shadow pipeline and DEQ logic stay in the top.

Test Plan:
- Client 0 writes addr 5 = 0xA5A5_0001, then reads addr 5 with RSP0_READY = 1 → RSP0_VALID exactly L cycles after the read issue, data 0xA5A5_0001; RSP1_VALID stays 0.
- Both clients issue continuous reads (addr 1 / addr 2, preloaded 0x11 / 0x22) with both readies high → grants alternate 0,1,0,1; responses alternate 0x11 / 0x22 at 1 per cycle.
- Client 1 read of addr 3 (0x33) with RSP1_READY held low for 10 cycles → RSP1_VALID and 0x33 held stable; REQ0_READY = 0 throughout; after RSP1_READY rises, one DEQ and the next op proceeds.
- PIPELINED = 1: a write then a read with a bubble between them → DEQ auto-drains the bubble; the read response is still delivered at L = 2 with no lost or duplicated beat.
- RST asserted for 1 cycle with 2 reads in flight → no RSP_VALID afterwards, pointer back to 0; a subsequent read of addr 7 returns the pre-reset written value.
- Only client 1 valid for 4 cycles, then both valid → client 1 is served every cycle, then client 0 wins the first contended cycle.

Source files
------------

// File: rtl/bram2_stall_port_arbiter_pkg.sv
// rtl/bram2_stall_port_arbiter_pkg.sv - shared types and helpers for the BRAM port arbiter
// Purpose: client tag type, read-latency helper and the request record used by
//          the arbiter top and its round-robin sub-module.
// Ports:   none (package).
package bram2_stall_port_arbiter_pkg;

    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_DATA_WIDTH = 32;

    // Identifies which of the two clients owns a request or a response.
    typedef logic tag_t;

    // Read latency of the BRAM port: one output register, plus one more when pipelined.
    function automatic int read_latency(input int pipelined);
        return (pipelined != 0) ? 2 : 1;
    endfunction

    typedef struct packed {
        logic                      write;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] data;
    } req_t;

endpackage

// File: rtl/bram2_stall_port_arbiter_if.sv
// rtl/bram2_stall_port_arbiter_if.sv - per-client request/response channel
// Purpose: valid/ready request channel and valid/ready read-response channel of
//          one client of the BRAM port arbiter.
// Ports:   master = client side (drives requests, consumes responses),
//          slave  = arbiter side (accepts requests, drives responses).
interface bram2_stall_port_arbiter_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_data;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;

    modport master (
        output req_valid, req_write, req_addr, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/bram2_stall_port_arbiter_rr_arb2.sv
// rtl/bram2_stall_port_arbiter_rr_arb2.sv - two-way round-robin arbiter
// Purpose: picks one of two requesters; the pointer prefers the client that
//          lost the previous grant.
// Ports:   i_clk, i_rst (sync, active high), i_req[1:0] request vector,
//          i_advance (a grant was taken this cycle), o_grant (winning client).
module bram2_rr_arb2
    import bram2_stall_port_arbiter_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output tag_t       o_grant
);

    tag_t r_ptr;

    always_comb begin
        o_grant = 1'b0;
        case (i_req)
            2'b01:   o_grant = 1'b0;
            2'b10:   o_grant = 1'b1;
            2'b11:   o_grant = r_ptr;
            default: o_grant = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= 1'b0;
        end else if (i_advance) begin
            r_ptr <= ~o_grant;
        end
    end

endmodule

// File: rtl/bram2_stall_port_arbiter.sv
// rtl/bram2_stall_port_arbiter.sv - shares one stall-capable BRAM port between two clients
// Purpose: round-robin issue of reads/writes from two clients onto one BRAM port,
//          a shadow {valid, tag} pipeline mirroring the BRAM read pipeline so each
//          read beat is routed to its owner, and DEQ generation that drains bubbles
//          and releases consumed beats without ever overwriting an unconsumed one.
// Ports:   i_clk, i_rst (sync, active high);
//          io_client0/io_client1 request/response channels (slave side);
//          o_bram_en/o_bram_we/o_bram_addr/o_bram_di/o_bram_deq to the BRAM port,
//          i_bram_do read data from the BRAM port.
module bram2_stall_port_arbiter
    import bram2_stall_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PIPELINED  = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    bram2_stall_port_arbiter_if.slave io_client0,
    bram2_stall_port_arbiter_if.slave io_client1,
    output logic                  o_bram_en,
    output logic                  o_bram_we,
    output logic [ADDR_WIDTH-1:0] o_bram_addr,
    output logic [DATA_WIDTH-1:0] o_bram_di,
    output logic                  o_bram_deq,
    input  logic [DATA_WIDTH-1:0] i_bram_do
);

    localparam int L = read_latency(PIPELINED);

    logic     [L-1:0] r_sv;
    tag_t     [L-1:0] r_st;

    logic w_head_v;
    tag_t w_head_t;
    logic w_head_accept;
    logic w_can_issue;
    logic w_issue;
    logic w_issue_read;
    logic w_ce;
    tag_t w_grant;
    req_t w_req;

    assign w_head_v      = r_sv[L-1];
    assign w_head_t      = r_st[L-1];
    assign w_head_accept = w_head_v &&
                           ((w_head_t == 1'b1) ? io_client1.rsp_ready : io_client0.rsp_ready);
    // Issuing shifts the shadow pipeline, so it is only safe when the head is empty
    // or leaves this cycle.
    assign w_can_issue   = !w_head_v || w_head_accept;
    assign w_issue       = !i_rst && w_can_issue && (io_client0.req_valid || io_client1.req_valid);
    assign w_issue_read  = w_issue && !w_req.write;

    bram2_rr_arb2 u_arb (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_req     ({io_client1.req_valid, io_client0.req_valid}),
        .i_advance (w_issue),
        .o_grant   (w_grant)
    );

    always_comb begin
        if (w_grant == 1'b1) begin
            w_req.write = io_client1.req_write;
            w_req.addr  = io_client1.req_addr;
            w_req.data  = io_client1.req_data;
        end else begin
            w_req.write = io_client0.req_write;
            w_req.addr  = io_client0.req_addr;
            w_req.data  = io_client0.req_data;
        end
    end

    assign o_bram_en   = w_issue;
    assign o_bram_we   = w_issue && w_req.write;
    assign o_bram_addr = w_issue ? w_req.addr : '0;
    assign o_bram_di   = w_issue ? w_req.data : '0;
    // Without an issue, still advance when the head is consumed or when an empty
    // head sits in front of a valid read, so bubbles collapse on their own.
    assign o_bram_deq  = !i_rst && !w_issue && (w_head_accept || (!w_head_v && (|r_sv)));
    assign w_ce        = o_bram_en || o_bram_deq;

    assign io_client0.req_ready = !i_rst && w_can_issue && (w_grant == 1'b0) && io_client0.req_valid;
    assign io_client1.req_ready = !i_rst && w_can_issue && (w_grant == 1'b1) && io_client1.req_valid;
    assign io_client0.rsp_valid = w_head_v && (w_head_t == 1'b0);
    assign io_client1.rsp_valid = w_head_v && (w_head_t == 1'b1);
    assign io_client0.rsp_data  = i_bram_do;
    assign io_client1.rsp_data  = i_bram_do;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sv <= '0;
            r_st <= '0;
        end else if (w_ce) begin
            r_sv[0] <= w_issue_read;
            r_st[0] <= w_grant;
            for (int i = 1; i < L; i++) begin
                r_sv[i] <= r_sv[i-1];
                r_st[i] <= r_st[i-1];
            end
        end
    end

endmodule
